// File: rtl/board_commit_ctrl_pkg.sv
// Shared game package: controller states, requester ids
// and board geometry used by the mux and piece engine.
package board_commit_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    WAIT_FRAME,
    COMMIT,
    LOCK
  } state_t;

  typedef enum logic {
    REQ_MOVE = 1'b0,
    REQ_DROP = 1'b1
  } req_id_t;

  localparam int BOARD_W     = 10;
  localparam int BOARD_H     = 22;
  localparam int BOARD_CELLS = BOARD_W * BOARD_H;
  localparam int CELL_BITS   = 3;

endpackage

// File: rtl/board_commit_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; the last-grant
// register only moves when both requesters contend.
module rr_arb2
  import board_commit_ctrl_pkg::*;
#(
  parameter bit RESET_LAST = 1'b1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    req_move,
  input  logic    req_drop,
  input  logic    take,
  output logic    valid,
  output req_id_t gnt
);

  req_id_t last;
  logic    tie;

  assign tie = req_move & req_drop;

  always_comb begin
    valid = req_move | req_drop;
    gnt   = REQ_MOVE;
    unique case (1'b1)
      tie:                   gnt = req_id_t'(~last);
      req_drop & ~req_move:  gnt = REQ_DROP;
      default:               gnt = REQ_MOVE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= req_id_t'(RESET_LAST);
    end else if (take & tie) begin
      last <= gnt;
    end
  end

endmodule

// File: rtl/board_commit_ctrl.sv
// Arbitrates move/drop candidates, waits for the collision
// verdict and commits clean boards only on a frame boundary.
module board_commit_ctrl
  import board_commit_ctrl_pkg::*;
#(
  parameter int CHECK_LAT     = 2,
  parameter int RR_RESET_LAST = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic move_req,
  input  logic drop_req,
  input  logic collide,
  input  logic frame_start,
  output logic src_sel,
  output logic board_we,
  output logic grant_move,
  output logic grant_drop,
  output logic lock_piece,
  output logic busy
);

  localparam logic [3:0] LAST_CNT = 4'(CHECK_LAT - 1);

  state_t     state, state_n;
  req_id_t    gid, gid_n;
  logic [3:0] cnt, cnt_n;
  logic       pm, pm_n;
  logic       pd, pd_n;
  logic       vis_m, vis_d;
  logic       arb_v, take;
  req_id_t    arb_g;
  logic       gm_n, gd_n, we_n, lk_n, bz_n;

  assign vis_m = pm | move_req;
  assign vis_d = pd | drop_req;

  rr_arb2 #(
    .RESET_LAST(RR_RESET_LAST[0])
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_move (vis_m),
    .req_drop (vis_d),
    .take     (take),
    .valid    (arb_v),
    .gnt      (arb_g)
  );

  always_comb begin
    state_n = state;
    gid_n   = gid;
    cnt_n   = cnt;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        if (arb_v) begin
          state_n = EVAL;
          gid_n   = arb_g;
          cnt_n   = '0;
          take    = 1'b1;
        end
      end
      EVAL: begin
        if (cnt == LAST_CNT) begin
          cnt_n = '0;
          if (!collide)
            state_n = WAIT_FRAME;
          else if (gid == REQ_DROP)
            state_n = LOCK;
          else
            state_n = IDLE;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      WAIT_FRAME: begin
        if (frame_start) state_n = COMMIT;
      end
      COMMIT:  state_n = IDLE;
      LOCK:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // a req arriving with its own grant stays as a fresh request
    pm_n = (take && gid_n == REQ_MOVE) ? (pm & move_req)
                                       : (pm | move_req);
    pd_n = (take && gid_n == REQ_DROP) ? (pd & drop_req)
                                       : (pd | drop_req);

    bz_n = (state_n != IDLE);
    gm_n = bz_n && (gid_n == REQ_MOVE);
    gd_n = bz_n && (gid_n == REQ_DROP);
    we_n = (state_n == COMMIT);
    lk_n = (state_n == LOCK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gid        <= REQ_MOVE;
      cnt        <= '0;
      pm         <= 1'b0;
      pd         <= 1'b0;
      src_sel    <= 1'b0;
      board_we   <= 1'b0;
      grant_move <= 1'b0;
      grant_drop <= 1'b0;
      lock_piece <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      gid        <= gid_n;
      cnt        <= cnt_n;
      pm         <= pm_n;
      pd         <= pd_n;
      src_sel    <= we_n;
      board_we   <= we_n;
      grant_move <= gm_n;
      grant_drop <= gd_n;
      lock_piece <= lk_n;
      busy       <= bz_n;
    end
  end

endmodule

// File: tb/tb_board_commit_ctrl.sv
// Bench for board_commit_ctrl: vector table plus
// hand sequences, events checked through a scoreboard.
module tb_board_commit_ctrl;
  import board_commit_ctrl_pkg::*;

  localparam int CL = 2;

  logic clk = 0;
  logic rst = 0;
  logic move_req = 0;
  logic drop_req = 0;
  logic collide = 0;
  logic frame_start = 0;
  logic src_sel, board_we;
  logic grant_move, grant_drop;
  logic lock_piece, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int kind;
    int who;
    int at;
  } ev_t;

  typedef struct {
    bit drop;
    bit col;
    int f1;
    int f2;
    int kind;
    int off;
    int idle;
  } vec_t;

  ev_t  sbq[$];
  vec_t vt[7];

  board_commit_ctrl #(
    .CHECK_LAT    (CL),
    .RR_RESET_LAST(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .move_req    (move_req),
    .drop_req    (drop_req),
    .collide     (collide),
    .frame_start (frame_start),
    .src_sel     (src_sel),
    .board_we    (board_we),
    .grant_move  (grant_move),
    .grant_drop  (grant_drop),
    .lock_piece  (lock_piece),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               n, act, exp);
    end
  endtask

  task automatic push(int kind, int who, int at);
    ev_t e;
    e.kind = kind;
    e.who  = who;
    e.at   = at;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    move_req    = 0;
    drop_req    = 0;
    collide     = 0;
    frame_start = 0;
  endtask

  ev_t me;
  always @(negedge clk) begin
    if (!rst) begin
      chk("src_sel_eq_we", src_sel, board_we);
      chk("grant_excl", grant_move & grant_drop, 0);
      if (board_we | lock_piece) begin
        if (sbq.size() == 0) begin
          chk("unexpected_event",
              {board_we, lock_piece}, 0);
        end else begin
          me = sbq.pop_front();
          chk("ev_kind", board_we ? 1 : 2, me.kind);
          chk("ev_cycle", cyc, me.at);
          chk("ev_who", grant_drop, me.who);
        end
      end
    end
  end

  initial begin
    vt[0] = '{1'b0, 1'b0,  7, -1, 1,  8, 9};
    vt[1] = '{1'b0, 1'b0,  3, -1, 1,  4, 5};
    vt[2] = '{1'b1, 1'b0, 10, -1, 1, 11, 12};
    vt[3] = '{1'b1, 1'b1, -1, -1, 2,  3, 4};
    vt[4] = '{1'b0, 1'b1, -1, -1, 0,  0, 3};
    vt[5] = '{1'b0, 1'b0,  2,  6, 1,  7, 8};
    vt[6] = '{1'b1, 1'b0,  1,  3, 1,  4, 5};

    #1 rst = 1;
    repeat (3) tick();
    chk("reset_outs",
        {src_sel, board_we, grant_move,
         grant_drop, lock_piece, busy}, 0);
    rst = 0;
    repeat (2) tick();

    foreach (vt[i]) begin
      for (int k = 0; k < 14; k++) begin
        tick();
        move_req    = (k == 0) && !vt[i].drop;
        drop_req    = (k == 0) && vt[i].drop;
        collide     = (k == CL) ? vt[i].col : !vt[i].col;
        frame_start = (k == vt[i].f1) || (k == vt[i].f2);
        if (k == 0 && vt[i].kind != 0)
          push(vt[i].kind, vt[i].drop, cyc + vt[i].off);
        @(negedge clk);
        if (k >= 1 && k < vt[i].idle) begin
          chk($sformatf("v%0d_busy_k%0d", i, k), busy, 1);
          chk($sformatf("v%0d_grant_k%0d", i, k),
              {grant_move, grant_drop},
              vt[i].drop ? 2'b01 : 2'b10);
        end else if (k == vt[i].idle) begin
          chk($sformatf("v%0d_idle", i),
              {busy, grant_move, grant_drop}, 0);
        end
      end
      idle_in();
    end

    for (int k = 0; k < 45; k++) begin
      tick();
      move_req    = (k == 0);
      drop_req    = (k == 0);
      collide     = 0;
      frame_start = (k > 0) && (k % 20 == 0);
      if (k == 0) begin
        push(1, 0, cyc + 21);
        push(1, 1, cyc + 41);
      end
      @(negedge clk);
      if (k == 1)  chk("tie_first_move", grant_move, 1);
      if (k == 22) chk("tie_gap_idle", busy, 0);
      if (k == 23) chk("tie_second_drop", grant_drop, 1);
    end
    idle_in();

    for (int k = 0; k < 121; k++) begin
      tick();
      move_req    = (k == 0) || (k == 10) ||
                    (k == 20) || (k == 30);
      collide     = 0;
      frame_start = (k == 1) || (k == 101) || (k == 110);
      if (k == 0) begin
        push(1, 0, cyc + 102);
        push(1, 0, cyc + 111);
      end
      @(negedge clk);
      if (k == 100) chk("eval_frame_ignored", busy, 1);
      if (k == 103) chk("merge_idle_gap", busy, 0);
      if (k == 104) chk("merge_regrant", grant_move, 1);
      if (k == 112 || k == 120)
        chk($sformatf("merge_single_k%0d", k), busy, 0);
    end
    idle_in();

    for (int k = 0; k < 9; k++) begin
      tick();
      move_req = (k == 0);
      drop_req = (k == 5);
      collide  = 0;
      @(negedge clk);
    end
    idle_in();
    chk("wait_busy_pre_rst", {busy, grant_move}, 2'b11);
    #2 rst = 1;
    #1;
    chk("async_rst_outs",
        {src_sel, board_we, grant_move,
         grant_drop, lock_piece, busy}, 0);
    tick();
    rst = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      frame_start = (k == 5) || (k == 15);
      @(negedge clk);
      chk($sformatf("post_rst_idle_k%0d", k),
          {busy, grant_move, grant_drop}, 0);
    end
    idle_in();
    repeat (2) tick();

    chk("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
